// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (A)
// and load/store (B). B wins contention unless A has been passed over
// STARVE_LIMIT times in a row. sel_a is a registered select for the
// address/wdata mux pair in front of the memory.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch port
  input  logic            a_req,
  input  logic [XLEN-1:0] a_addr,
  output logic            a_ack,
  output logic [XLEN-1:0] a_rdata,
  // load/store port
  input  logic            b_req,
  input  logic            b_we,
  input  logic [XLEN-1:0] b_addr,
  input  logic [XLEN-1:0] b_wdata,
  output logic            b_ack,
  output logic [XLEN-1:0] b_rdata,
  // memory side
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  // status
  output logic            sel_a,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  // A limit of 0 still needs a 1-bit counter; it simply never leaves 0,
  // so streak==LIMIT always holds and A always wins contention.
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  state_t        state, state_nxt;
  logic          sel_a_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          grant_a, grant_b;
  logic          contended;

  // Grant decision, only meaningful in IDLE
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    contended = a_req && b_req;
    if (state == IDLE) begin
      if (contended) begin
        grant_a = (streak == LIMIT);
        grant_b = (streak != LIMIT);
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  // Next state, select and starvation streak
  always_comb begin
    state_nxt  = state;
    sel_a_nxt  = sel_a;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        if (grant_a) begin
          state_nxt  = BUSY_A;
          sel_a_nxt  = 1'b1;
          streak_nxt = '0;
        end else if (grant_b) begin
          state_nxt = BUSY_B;
          sel_a_nxt = 1'b0;
          // only a B grant that made A wait counts toward starvation
          if (a_req && (streak != LIMIT))
            streak_nxt = streak + SW'(1);
        end
      end
      BUSY_A, BUSY_B: begin
        if (mem_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel_a  <= 1'b0;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      sel_a  <= sel_a_nxt;
      streak <= streak_nxt;
    end
  end

  // Memory side is a pure decode of registered state and select
  assign mem_req   = (state != IDLE);
  assign busy      = (state != IDLE);
  assign mem_we    = mem_req && !sel_a && b_we;
  assign mem_addr  = sel_a ? a_addr : b_addr;
  assign mem_wdata = b_wdata;

  // Acks coincide with mem_ready; read data is a straight pass-through
  assign a_ack   = (state == BUSY_A) && mem_ready;
  assign b_ack   = (state == BUSY_B) && mem_ready;
  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (XLEN=32, STARVE_LIMIT=4).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req;
  logic [31:0] a_addr;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        sel_a;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sel_a(sel_a), .busy(busy)
  );

  always #5 clk = ~clk;

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_req = 0; b_req = 0; b_we = 0; mem_ready = 0;
    a_addr = '0; b_addr = '0; b_wdata = '0; mem_rdata = '0;
    tick(); tick();
    #1;
    n_checks++;
    if ({busy, mem_req, sel_a, a_ack, b_ack} !== 5'b0) begin
      n_fail++; $display("FAIL reset_init: busy/req/sel/aack/back=%b expected 00000", {busy, mem_req, sel_a, a_ack, b_ack});
    end
    // enter BUSY_B, then reset mid-access for two cycles
    rst_n = 1'b1; b_req = 1; b_addr = 32'h40;
    tick();
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_b: mem_req=%b expected 1", mem_req);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({busy, mem_req, sel_a, b_ack} !== 4'b0) begin
        n_fail++; $display("FAIL reset_mid: busy/req/sel/back=%b expected 0000", {busy, mem_req, sel_a, b_ack});
      end
    end
    n_checks++;
    if (dut.streak !== 3'd0) begin
      n_fail++; $display("FAIL reset_streak: streak=%0d expected 0", dut.streak);
    end
    // b_req still held: granted normally after release
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({mem_req, sel_a, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      n_fail++; $display("FAIL reset_regrant: req=%b sel_a=%b addr=%h expected 1 0 00000040", mem_req, sel_a, mem_addr);
    end
    mem_ready = 1; #1;
    n_checks++;
    if (b_ack !== 1'b1) begin
      n_fail++; $display("FAIL reset_regrant_ack: b_ack=%b expected 1", b_ack);
    end
    tick();
    b_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_single_fetch();
    int acks = 0;
    a_req = 1; a_addr = 32'h100;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({mem_req, sel_a, mem_addr, mem_we} !== {1'b1, 1'b1, 32'h100, 1'b0}) begin
        n_fail++; $display("FAIL fetch_hold: req=%b sel_a=%b addr=%h we=%b expected 1 1 00000100 0", mem_req, sel_a, mem_addr, mem_we);
      end
      if (a_ack) acks++;
      tick();
    end
    mem_ready = 1; mem_rdata = 32'hDEADBEEF; #1;
    n_checks++;
    if ({a_ack, b_ack, sel_a, mem_addr, a_rdata} !== {1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL fetch_ack: aack=%b back=%b sel=%b addr=%h rdata=%h expected 1 0 1 00000100 deadbeef", a_ack, b_ack, sel_a, mem_addr, a_rdata);
    end
    if (a_ack) acks++;
    tick();
    a_req = 0; mem_ready = 0;
    if (a_ack) acks++;
    tick();
    if (a_ack) acks++;
    n_checks++;
    if (acks !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pulses: a_ack pulses=%0d busy=%b expected 1 0", acks, busy);
    end
  endtask

  task automatic test_store();
    b_req = 1; b_we = 1; b_addr = 32'h2000; b_wdata = 32'h12345678;
    tick();
    n_checks++;
    if ({mem_req, sel_a, mem_we, mem_addr, mem_wdata, b_ack, a_ack} !==
        {1'b1, 1'b0, 1'b1, 32'h2000, 32'h12345678, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL store_drive: req=%b sel=%b we=%b addr=%h wdata=%h back=%b aack=%b", mem_req, sel_a, mem_we, mem_addr, mem_wdata, b_ack, a_ack);
    end
    mem_ready = 1; #1;
    n_checks++;
    if ({b_ack, a_ack} !== 2'b10) begin
      n_fail++; $display("FAIL store_ack: back/aack=%b expected 10", {b_ack, a_ack});
    end
    tick();
    b_req = 0; b_we = 0; mem_ready = 0;
    n_checks++;
    if ({busy, b_ack, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL store_done: busy/back/we=%b expected 000", {busy, b_ack, mem_we});
    end
    tick();
  endtask

  task automatic test_simultaneous();
    a_req = 1; b_req = 1; a_addr = 32'h300; b_addr = 32'h500;
    tick();
    n_checks++;
    if ({mem_req, sel_a, mem_addr, dut.streak} !== {1'b1, 1'b0, 32'h500, 3'd1}) begin
      n_fail++; $display("FAIL simul_b_first: req=%b sel=%b addr=%h streak=%0d expected 1 0 00000500 1", mem_req, sel_a, mem_addr, dut.streak);
    end
    mem_ready = 1; #1;
    n_checks++;
    if (b_ack !== 1'b1) begin
      n_fail++; $display("FAIL simul_b_ack: b_ack=%b expected 1", b_ack);
    end
    tick();
    b_req = 0; mem_ready = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL simul_bubble: busy=%b expected 0", busy);
    end
    tick();
    n_checks++;
    if ({mem_req, sel_a, mem_addr, dut.streak} !== {1'b1, 1'b1, 32'h300, 3'd0}) begin
      n_fail++; $display("FAIL simul_a_second: req=%b sel=%b addr=%h streak=%0d expected 1 1 00000300 0", mem_req, sel_a, mem_addr, dut.streak);
    end
    mem_ready = 1; #1;
    n_checks++;
    if (a_ack !== 1'b1) begin
      n_fail++; $display("FAIL simul_a_ack: a_ack=%b expected 1", a_ack);
    end
    tick();
    a_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_contention();
    logic exp_sel;
    a_req = 1; b_req = 1; mem_ready = 1;
    for (int g = 0; g < 10; g++) begin
      tick();
      exp_sel = (g % 5 == 4);
      n_checks++;
      if ({busy, sel_a} !== {1'b1, exp_sel}) begin
        n_fail++; $display("FAIL contention_grant%0d: busy=%b sel_a=%b expected 1 %b", g, busy, sel_a, exp_sel);
      end
      tick();
    end
    a_req = 0; b_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_stall();
    int bad = 0;
    a_req = 1; a_addr = 32'h700;
    tick();
    b_req = 1; b_we = 0; b_addr = 32'h900;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ({sel_a, mem_req, mem_addr, b_ack, a_ack} !== {1'b1, 1'b1, 32'h700, 1'b0, 1'b0}) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL stall_hold: %0d bad cycles expected 0", bad);
    end
    mem_ready = 1; mem_rdata = 32'hCAFEF00D; #1;
    n_checks++;
    if ({a_ack, b_ack, a_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL stall_a_ack: aack=%b back=%b rdata=%h expected 1 0 cafef00d", a_ack, b_ack, a_rdata);
    end
    tick();
    a_req = 0; mem_ready = 0;
    tick();
    n_checks++;
    if ({mem_req, sel_a, mem_addr} !== {1'b1, 1'b0, 32'h900}) begin
      n_fail++; $display("FAIL stall_b_after: req=%b sel=%b addr=%h expected 1 0 00000900", mem_req, sel_a, mem_addr);
    end
    mem_ready = 1; #1;
    n_checks++;
    if (b_ack !== 1'b1) begin
      n_fail++; $display("FAIL stall_b_ack: b_ack=%b expected 1", b_ack);
    end
    tick();
    b_req = 0; mem_ready = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_contention();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
